// File: rtl/fifo_wr_ctrl_pkg.sv
// rtl/fifo_wr_ctrl_pkg.sv - shared dual-clock FIFO defaults and Gray/binary pointer helpers
package fifo_wr_ctrl_pkg;

    localparam int FIFO_ADDR_WIDTH  = 3;
    localparam int FIFO_SYNC_STAGES = 2;

    // Helpers work on a wide word; callers zero-extend in and truncate out.
    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = '0;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// rtl/fifo_ptr_sync.sv - multi-bit, multi-stage pointer synchronizer with async active-low reset
module fifo_ptr_sync
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int WIDTH  = FIFO_ADDR_WIDTH + 1,
    parameter int STAGES = FIFO_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-domain pointer, full flag and fill count of the dual-clock FIFO
module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int SYNC_STAGES = FIFO_SYNC_STAGES
) (
    input  logic                  W_CLK,
    input  logic                  W_RST,
    input  logic                  W_INC,
    input  logic [ADDR_WIDTH:0]   R_PTR,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [ADDR_WIDTH:0]   W_PTR,
    output logic                  W_FULL,
    output logic [ADDR_WIDTH:0]   W_COUNT
);

    localparam int PW = ADDR_WIDTH + 1;

    logic          w_acc;
    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq_gray_pre;
    logic [PW-1:0] rq_bin_pre;
    logic [PW-1:0] full_ptr;

    // The W_FULL/W_COUNT registers form the last stage of the read-pointer
    // crossing, so an R_PTR change is reflected exactly SYNC_STAGES edges later.
    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES - 1)
    ) u_rptr_sync (
        .clk   (W_CLK),
        .rst_n (W_RST),
        .d     (R_PTR),
        .q     (rq_gray_pre)
    );

    assign w_acc      = W_INC & ~W_FULL;
    assign wbin_next  = wbin + PW'(w_acc);
    assign wgray_next = PW'(bin2gray(ptr_word_t'(wbin_next)));
    assign rq_bin_pre = PW'(gray2bin(ptr_word_t'(rq_gray_pre)));

    // Full when the write pointer has lapped the read pointer by one full turn.
    assign full_ptr = {~rq_gray_pre[PW-1:PW-2], rq_gray_pre[PW-3:0]};

    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wbin    <= '0;
            W_PTR   <= '0;
            W_FULL  <= 1'b0;
            W_COUNT <= '0;
        end else begin
            wbin    <= wbin_next;
            W_PTR   <= wgray_next;
            W_FULL  <= (wgray_next == full_ptr);
            W_COUNT <= wbin_next - rq_bin_pre;
        end
    end

    assign W_ADDR = wbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - scoreboard bench for fifo_wr_ctrl with directed vectors
module tb_fifo_wr_ctrl;

    logic       W_CLK = 1'b0;
    logic       W_RST = 1'b0;
    logic       W_INC = 1'b0;
    logic [3:0] R_PTR = 4'd0;
    logic [2:0] W_ADDR;
    logic [3:0] W_PTR;
    logic       W_FULL;
    logic [3:0] W_COUNT;

    always #5 W_CLK = ~W_CLK;

    fifo_wr_ctrl #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2)
    ) dut (
        .W_CLK   (W_CLK),
        .W_RST   (W_RST),
        .W_INC   (W_INC),
        .R_PTR   (R_PTR),
        .W_ADDR  (W_ADDR),
        .W_PTR   (W_PTR),
        .W_FULL  (W_FULL),
        .W_COUNT (W_COUNT)
    );

    typedef struct {
        string      nm;
        logic [2:0] addr;
        logic [3:0] ptr;
        logic       full;
        logic [3:0] cnt;
        bit         cnt_le;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    event chk_ev;

    logic [3:0] fill_ptr [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    logic [3:0] wv;
    logic [3:0] wn;

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic expect_now(input string nm, input logic [2:0] ea, input logic [3:0] ep,
                              input logic ef, input logic [3:0] ec, input bit le);
        exp_t e;
        e.nm = nm; e.addr = ea; e.ptr = ep; e.full = ef; e.cnt = ec; e.cnt_le = le;
        sb.push_back(e);
    endtask

    task automatic tick(input logic inc, input logic [3:0] rp, input string nm,
                        input logic [2:0] ea, input logic [3:0] ep, input logic ef,
                        input logic [3:0] ec, input bit le);
        W_INC = inc;
        R_PTR = rp;
        @(posedge W_CLK);
        #1;
        expect_now(nm, ea, ep, ef, ec, le);
    endtask

    task automatic async_reset(input string nm, input logic [3:0] rp);
        @(negedge W_CLK);
        #1;
        R_PTR = rp;
        W_INC = 1'b1;
        W_RST = 1'b0;
        #1;
        expect_now(nm, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        ->chk_ev;
        tick(1'b1, rp, {nm, "_hold"}, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        W_RST = 1'b1;
        W_INC = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge W_CLK or chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.nm, "_addr"}, 32'(W_ADDR), 32'(e.addr));
                chk({e.nm, "_ptr"},  32'(W_PTR),  32'(e.ptr));
                chk({e.nm, "_full"}, 32'(W_FULL), 32'(e.full));
                if (e.cnt_le) begin
                    n_total++;
                    if (W_COUNT <= e.cnt) n_pass++;
                    else $display("FAIL %s_cnt_le: got %0d expected <= %0d", e.nm, W_COUNT, e.cnt);
                end else begin
                    chk({e.nm, "_cnt"}, 32'(W_COUNT), 32'(e.cnt));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1);
    end

    initial begin : stim
        W_RST = 1'b0;
        tick(1'b1, 4'd0, "por0", 3'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick(1'b0, 4'd0, "por1", 3'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        W_RST = 1'b1;

        tick(1'b1, 4'd0, "pre1", 3'd1, 4'b0001, 1'b0, 4'd1, 1'b0);
        tick(1'b1, 4'd0, "pre2", 3'd2, 4'b0011, 1'b0, 4'd2, 1'b0);
        tick(1'b1, 4'd0, "pre3", 3'd3, 4'b0010, 1'b0, 4'd3, 1'b0);
        async_reset("rst_mid", 4'd0);
        tick(1'b1, 4'd0, "first_wr", 3'd1, 4'b0001, 1'b0, 4'd1, 1'b0);

        async_reset("rst_fill", 4'd0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 4'd0, "fill", 3'(k + 1), fill_ptr[k], (k == 7), 4'(k + 1), 1'b0);
        end
        tick(1'b1, 4'd0, "fill_9th", 3'd0, 4'b1100, 1'b1, 4'd8, 1'b0);

        tick(1'b0, 4'b0001, "drain_e1", 3'd0, 4'b1100, 1'b1, 4'd8, 1'b0);
        tick(1'b0, 4'b0001, "drain_e2", 3'd0, 4'b1100, 1'b0, 4'd7, 1'b0);

        tick(1'b0, 4'b0011, "simul_pre", 3'd0, 4'b1100, 1'b0, 4'd7, 1'b0);
        tick(1'b1, 4'b0011, "simul",     3'd1, 4'b1101, 1'b0, 4'd7, 1'b0);

        async_reset("rst_wrap", 4'd0);
        wv = 4'd0;
        for (int i = 0; i < 20; i++) begin
            wn = wv + 4'd1;
            tick(1'b0, g(wv), "wrap_idle", wv[2:0], g(wv), 1'b0, 4'd1, 1'b1);
            tick(1'b0, g(wv), "wrap_idle", wv[2:0], g(wv), 1'b0, 4'd1, 1'b1);
            tick(1'b1, g(wv), "wrap_wr",   wn[2:0], g(wn), 1'b0, 4'd1, 1'b0);
            wv = wn;
        end

        async_reset("rst_pre_burst", 4'd0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 4'd0, "burst", 3'(k + 1), fill_ptr[k], 1'b0, 4'(k + 1), 1'b0);
        end
        async_reset("rst_burst", 4'b0111);
        tick(1'b0, 4'b0111, "resync_e1", 3'd0, 4'd0, 1'b0, 4'd0,  1'b0);
        tick(1'b0, 4'b0111, "resync_e2", 3'd0, 4'd0, 1'b0, 4'd11, 1'b0);

        @(negedge W_CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side pointer and full-flag controller of the team's dual-clock FIFO, running entirely in the write clock domain. It accepts write requests, advances a binary/Gray write pointer pair, drives the write address into the FIFO memory, and brings the read-domain Gray pointer across with a two-flop synchronizer. It produces a registered full flag and a conservative fill count. It sits directly upstream of the FIFO memory controller, driving its W_ADDR and W_FULL inputs. Its W_PTR output feeds the read-side controller's synchronizer.

## Interface
- ADDR_WIDTH, 3: memory address width; the FIFO holds 2^ADDR_WIDTH entries, and pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2: flop stages in the read-pointer synchronizer; legal range 2–3.

- W_CLK  in  1  write-domain clock; the only clock.
- W_RST  in  1  reset, asynchronous and active-low.
- W_INC  in  1  write request from the producer.
- R_PTR  in  ADDR_WIDTH+1  Gray-coded read pointer from the read domain, not synchronized.
- W_ADDR  out  ADDR_WIDTH  memory write address; the low bits of the binary write pointer.
- W_PTR  out  ADDR_WIDTH+1  registered Gray-coded write pointer, sent to the read domain.
- W_FULL  out  1  registered full flag.
- W_COUNT  out  ADDR_WIDTH+1  entries currently held, from the write side's view; range 0..2^ADDR_WIDTH.

## Operation
- Accepted write: W_INC & !W_FULL, called W_ACC below. W_INC while full is ignored: no pointer change and no error state.
- Binary pointer wbin (ADDR_WIDTH+1 bits) counts modulo 2^(ADDR_WIDTH+1).
  - wbin_next = wbin + W_ACC.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- W_ADDR = wbin[ADDR_WIDTH-1:0]. The MSB is the wrap bit.
- W_PTR is registered from wgray_next. Only one bit changes per increment, which makes it safe to cross domains.
- Synchronizer: SYNC_STAGES flops on R_PTR; the final stage is rq_gray.
- Full is registered: W_FULL <= (wgray_next == {~rq_gray[MSB:MSB-1], rq_gray[MSB-2:0]}).
- Count:
  - rq_bin is the Gray-to-binary conversion of rq_gray (XOR prefix from the MSB).
  - W_COUNT <= wbin_next - rq_bin, modulo 2^(ADDR_WIDTH+1).
- Pessimism: the read pointer is stale by the synchronizer latency. W_FULL can stay asserted after reads, and W_COUNT can over-report. Neither may ever under-report.
- Simultaneous accepted write and synchronized read advance: both feed the same-edge full and count computation. Full deasserts and reasserts correctly, with no lost write.
- Reset (asynchronous assert, any time, including mid-burst): wbin, W_PTR, every synchronizer stage, W_FULL and W_COUNT clear to 0.
- Reset release is synchronous to W_CLK. It is the integration's job to provide that.

## Timing
- Reset values: W_ADDR=0, W_PTR=0, W_FULL=0, W_COUNT=0.
- Write accepted on edge N: W_ADDR and W_PTR update at edge N. The memory captures data at edge N using the pre-edge W_ADDR.
- W_FULL and W_COUNT reflect the write at edge N; there is no extra cycle of latency.
- R_PTR change to the W_FULL/W_COUNT update: SYNC_STAGES edges (2 by default).
- W_FULL never glitches; all outputs are flop outputs.

## Structure
- A shared FIFO package holds the ADDR_WIDTH default and the bin2gray/gray2bin functions. The read-side controller reuses them.
- One sub-module, fifo_ptr_sync: a parameterized multi-bit, multi-stage synchronizer (WIDTH, STAGES) with asynchronous active-low reset. The read side instantiates the same module.
- Pointer/flag logic stays in fifo_wr_ctrl.

## Test plan
All scenarios use ADDR_WIDTH=3 and SYNC_STAGES=2.
- **Reset:** W_RST low mid-clock with W_INC=1 → all outputs 0 immediately, without waiting for an edge. After release, the first write gives W_ADDR=1 and W_PTR=4'b0001.
- **Fill:** R_PTR=0, W_INC=1 for 8 edges.
  - W_ADDR steps 0..7; W_PTR ends at 4'b1100.
  - W_FULL=1 and W_COUNT=8 after the 8th edge.
  - A 9th W_INC leaves W_ADDR=0 and W_PTR=4'b1100 unchanged.
- **Drain release:** while full, set R_PTR=4'b0001 → W_FULL=0 and W_COUNT=7 exactly 2 edges later, not 1.
- **Wrap-around:** with R_PTR tracking the write pointer one entry behind, run 20 writes.
  - W_PTR passes 4'b1000 → 4'b0000, changing one bit per step.
  - W_FULL stays 0 and W_COUNT stays ≤1.
- **Simultaneous events:** count=7 with a read update arriving on the same edge as a write → W_FULL stays 0 and W_COUNT stays 7.
- **Reset mid-burst:** assert W_RST after 5 writes → the pointers and the synchronizer clear. R_PTR=4'b0111 is held constant across reset, so the W_COUNT seen after 2 edges reflects only the resynchronized value.
